// File: rtl/ffnn_layer_mac.sv
// ffnn_layer_mac: one fully-connected layer, time-shared MAC, step activation; FFNN_BIAS_EN adds per-neuron bias
module ffnn_layer_mac #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2,
  parameter int IN_W  = 8,
  parameter int W_W   = 8,
  parameter int ACC_W = 20,
  parameter int AW    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [N_IN*IN_W-1:0]   x_flat,
  output logic                   busy,
  output logic                   done,
  output logic [N_OUT*ACC_W-1:0] z_flat,
  output logic [N_OUT-1:0]       y,
  input  logic                   w_we,
  input  logic [AW-1:0]          w_addr,
  input  logic [W_W-1:0]         w_data,
  output logic                   wr_drop
);
  localparam int NW = N_IN * N_OUT;
  localparam int IW = N_IN > 1 ? $clog2(N_IN) : 1;
  localparam int JW = N_OUT > 1 ? $clog2(N_OUT) : 1;
  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
  state_t state, state_n;
  logic [N_IN*IN_W-1:0] x_reg;
  logic [NW*W_W-1:0] w_reg;
  logic [IW-1:0] i;
  logic [JW-1:0] j;
  logic signed [ACC_W-1:0] acc, sum, acc0, acc_nb;
  logic signed [IN_W:0] xs;
  logic signed [W_W-1:0] wv;
  logic signed [IN_W+W_W:0] prod;
  logic last_i, last_j, w_ok, w_acc;
`ifdef FFNN_BIAS_EN
  logic [N_OUT*W_W-1:0] b_reg;
  function automatic logic signed [ACC_W-1:0] sext(input logic [W_W-1:0] v);
    return {{(ACC_W-W_W){v[W_W-1]}}, v};
  endfunction
`endif
  always_comb begin
    xs = $signed({1'b0, x_reg[i*IN_W +: IN_W]});
    wv = $signed(w_reg[(j*N_IN+i)*W_W +: W_W]);
    prod = xs * wv;
    sum = acc + {{(ACC_W-IN_W-W_W-1){prod[IN_W+W_W]}}, prod};
    last_i = i == IW'(N_IN-1);
    last_j = j == JW'(N_OUT-1);
`ifdef FFNN_BIAS_EN
    acc0 = sext(b_reg[W_W-1:0]);
    acc_nb = last_j ? '0 : sext(b_reg[(j+1)*W_W +: W_W]);
    w_ok = w_addr < AW'(NW+N_OUT);
`else
    acc0 = '0;
    acc_nb = '0;
    w_ok = w_addr < AW'(NW);
`endif
    w_acc = w_we && state == IDLE && w_ok;
    state_n = state == IDLE ? (start ? MAC : IDLE) :
              state == MAC  ? (last_i && last_j ? DONE : MAC) : IDLE;
    busy = state == MAC;
    done = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      x_reg <= '0;
      w_reg <= '0;
`ifdef FFNN_BIAS_EN
      b_reg <= '0;
`endif
      i <= '0;
      j <= '0;
      acc <= '0;
      z_flat <= '0;
      y <= '0;
      wr_drop <= 1'b0;
    end else begin
      state <= state_n;
      wr_drop <= w_we && !w_acc;
`ifdef FFNN_BIAS_EN
      if (w_acc && w_addr >= AW'(NW)) b_reg[(w_addr-AW'(NW))*W_W +: W_W] <= w_data;
`endif
      if (w_acc && w_addr < AW'(NW)) w_reg[w_addr*W_W +: W_W] <= w_data;
      if (state == IDLE && start) begin
        x_reg <= x_flat;
        i <= '0;
        j <= '0;
        acc <= acc0;
      end
      if (state == MAC && !last_i) begin
        acc <= sum;
        i <= i + 1'b1;
      end
      // neuron finished: publish result and preload the next neuron's start value
      if (state == MAC && last_i) begin
        z_flat[j*ACC_W +: ACC_W] <= sum;
        y[j] <= sum > 0;
        i <= '0;
        j <= last_j ? '0 : j + 1'b1;
        acc <= acc_nb;
      end
    end
  end
endmodule

// File: tb/tb_ffnn_layer_mac.sv
// tb_ffnn_layer_mac: randomized and directed checks of ffnn_layer_mac against an arithmetic reference model
module tb_ffnn_layer_mac;
  localparam int NW = 8;
`ifdef FFNN_BIAS_EN
  localparam int LIM = 10;
  localparam bit BIAS = 1;
`else
  localparam int LIM = 8;
  localparam bit BIAS = 0;
`endif
  logic clk = 0, reset = 1, start = 0, w_we = 0;
  logic [31:0] x_flat = '0;
  logic busy, done, wr_drop;
  logic [39:0] z_flat;
  logic [1:0] y;
  logic [3:0] w_addr = '0;
  logic [7:0] w_data = '0;
  int checks = 0, errors = 0;
  longint wm [NW];
  longint bm [2];
  longint xm [4];

  ffnn_layer_mac dut (.clk(clk), .reset(reset), .start(start), .x_flat(x_flat), .busy(busy),
    .done(done), .z_flat(z_flat), .y(y), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .wr_drop(wr_drop));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint zo(input int jj);
    logic signed [19:0] v;
    v = z_flat[jj*20 +: 20];
    return longint'(v);
  endfunction

  function automatic longint mz(input int jj);
    longint s;
    s = BIAS ? bm[jj] : 0;
    for (int k = 0; k < 4; k++) s += xm[k] * wm[jj*4+k];
    return s;
  endfunction

  task automatic mwrite(input int a, input logic [7:0] d);
    logic signed [7:0] t;
    t = d;
    if (a < NW) wm[a] = t;
    else if (a < LIM) bm[a-NW] = t;
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    w_we = 1; w_addr = 4'(a); w_data = d;
    tick();
    w_we = 0;
    chk("wr_drop_idle", wr_drop, a >= LIM);
    mwrite(a, d);
  endtask

  // runs one evaluation; smask bit k drives start in cycle k, wc is the cycle of a weight write (-1 none)
  task automatic run(input logic [31:0] xv, input int smask, input int wc, input int wa, input logic [7:0] wd);
    longint e0, e1;
    x_flat = xv; start = 1;
    for (int k = 0; k < 4; k++) xm[k] = xv[k*8 +: 8];
    if (wc == 0) begin w_we = 1; w_addr = 4'(wa); w_data = wd; end
    tick();
    start = 0; w_we = 0;
    if (wc == 0) mwrite(wa, wd);
    e0 = mz(0); e1 = mz(1);
    for (int k = 1; k <= 10; k++) begin
      chk("busy", busy, k <= 8);
      chk("done", done, k == 9);
      chk("wr_drop_run", wr_drop, wc > 0 && k == wc + 1);
      if (k == 5) chk("z0_early", zo(0), e0);
      if (k < 10) begin
        start = smask[k]; x_flat = $urandom; w_we = k == wc; w_addr = 4'(wa); w_data = wd;
        tick();
        start = 0; w_we = 0;
      end
    end
    chk("z0", zo(0), e0);
    chk("z1", zo(1), e1);
    chk("y", y, {1'b0, e1 > 0, e0 > 0});
  endtask

  initial begin
    for (int k = 0; k < NW; k++) wm[k] = 0;
    bm[0] = 0; bm[1] = 0;
    tick(); tick();
    reset = 0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_z", z_flat, 0);
    chk("rst_y", y, 0);
    chk("rst_wr_drop", wr_drop, 0);
    // basic dot products
    for (int k = 0; k < 4; k++) begin wr(k, 8'(k + 1)); wr(4 + k, 8'hff); end
    run({8'd40, 8'd30, 8'd20, 8'd10}, 0, -1, 0, 0);
    chk("t1_z0", zo(0), 300);
    chk("t1_z1", zo(1), -100);
    chk("t1_y", y, 2'b01);
    // extremes must not wrap
    for (int k = 0; k < NW; k++) wr(k, 8'h80);
    run(32'hffffffff, 0, -1, 0, 0);
    chk("t2_zmin", zo(1), -130560);
    for (int k = 0; k < NW; k++) wr(k, 8'h7f);
    run(32'hffffffff, 0, -1, 0, 0);
    chk("t2_zmax", zo(0), 129540);
    chk("t2_y", y, 2'b11);
    // start while busy or in DONE ignored; start right after DONE accepted
    run($urandom, (1 << 3) | (1 << 9), -1, 0, 0);
    run($urandom, 0, -1, 0, 0);
    // write during MAC dropped, write on start cycle accepted, bad address dropped
    run($urandom, 0, 2, 0, 8'h05);
    run($urandom, 0, 0, 3, 8'hf0);
    wr(15, 8'h11);
    // bias (dropped when the bias build is off)
    for (int k = 0; k < 4; k++) begin wr(k, 8'(k + 1)); wr(4 + k, 8'hff); end
    wr(8, 8'(-100));
    wr(9, 8'd101);
    run({8'd40, 8'd30, 8'd20, 8'd10}, 0, -1, 0, 0);
    chk("t6_z0", zo(0), BIAS ? 200 : 300);
    chk("t6_z1", zo(1), BIAS ? 1 : -100);
    chk("t6_y", y, BIAS ? 2'b11 : 2'b01);
    // randomized
    for (int r = 0; r < 20; r++) begin
      for (int n = 0; n < 3; n++) wr($urandom_range(0, 15), 8'($urandom));
      run($urandom, $urandom_range(0, 1023) & ~1, $urandom_range(0, 12) > 9 ? -1 : $urandom_range(0, 9),
          $urandom_range(0, NW - 1), 8'($urandom));
    end
    // reset mid-run aborts and clears
    x_flat = $urandom; start = 1;
    tick();
    start = 0;
    tick(); tick(); tick();
    reset = 1;
    tick();
    reset = 0;
    chk("abort_busy", busy, 0);
    chk("abort_z", z_flat, 0);
    chk("abort_y", y, 0);
    for (int k = 0; k < 8; k++) begin chk("abort_done", done, 0); tick(); end
    for (int k = 0; k < NW; k++) wm[k] = 0;
    bm[0] = 0; bm[1] = 0;
    run($urandom, 0, -1, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
